// File: rtl/ps2_kb_receiver_if.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_kb_receiver_if
//  Description : Bundle of the PS/2 line inputs and the scan-code outputs of
//                the keyboard receiver. The master side is the receiver; the
//                slave side is whatever drives the lines and consumes codes.
//  Revision    : 1.0 - initial release
// ============================================================================
interface ps2_kb_receiver_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] data_kb;
  logic       key_release;
  logic       data_valid;
  logic       rx_err;

  modport master (
    input  ps2_clk,
    input  ps2_data,
    output data_kb,
    output key_release,
    output data_valid,
    output rx_err
  );

  modport slave (
    output ps2_clk,
    output ps2_data,
    input  data_kb,
    input  key_release,
    input  data_valid,
    input  rx_err
  );
endinterface
`default_nettype wire

// File: rtl/ps2_kb_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_kb_receiver
//  Description : PS/2 device-to-host frame receiver. Synchronises the raw
//                lines, deserialises 11-bit frames on ps2_clk falls, checks
//                odd parity and stop bit, folds the F0 break prefix into
//                key_release, drops E0 prefixes and aborts stalled frames.
//  Revision    : 1.0 - initial release
// ============================================================================
module ps2_kb_receiver #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  wire logic         clk,
  input  wire logic         rst,
  ps2_kb_receiver_if.master kb
);

  localparam int                c_TO_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_TO_W-1:0] c_TO_MAX = c_TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]        c_LAST   = 4'd9;   // falls after start: D0..D7, parity
  localparam logic [7:0]        c_BREAK  = 8'hF0;
  localparam logic [7:0]        c_EXTEND = 8'hE0;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RX   = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_clk_meta, r_clk_s, r_clk_prev;
  logic                r_dat_meta, r_dat_s;
  logic [3:0]          r_bit_cnt;
  logic [8:0]          r_shift;
  logic [c_TO_W-1:0]   r_to_cnt;
  logic                r_brk;
  logic [7:0]          r_data_kb;
  logic                r_key_release;
  logic                r_data_valid;
  logic                r_rx_err;
  logic                w_fall;
  logic                w_shift_en;
  logic                w_frame_done;
  logic                w_timeout;
  logic                w_frame_ok;
  logic                w_frame_bad;

  // Two-stage synchronisers plus one extra ps2_clk stage for fall detection
  always_ff @(posedge clk) begin
    if (rst) begin
      r_clk_meta <= 1'b1;
      r_clk_s    <= 1'b1;
      r_clk_prev <= 1'b1;
      r_dat_meta <= 1'b1;
      r_dat_s    <= 1'b1;
    end else begin
      r_clk_meta <= kb.ps2_clk;
      r_clk_s    <= r_clk_meta;
      r_clk_prev <= r_clk_s;
      r_dat_meta <= kb.ps2_data;
      r_dat_s    <= r_dat_meta;
    end
  end

  assign w_fall = r_clk_prev & ~r_clk_s;

  // Frame state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state decode: start detection, bit shifting, frame end and timeout
  always_comb begin
    w_state_nxt  = r_state;
    w_shift_en   = 1'b0;
    w_frame_done = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_fall && !r_dat_s) w_state_nxt = ST_RX;
      end
      ST_RX: begin
        if (w_fall) begin
          if (r_bit_cnt == c_LAST) begin
            w_frame_done = 1'b1;
            w_state_nxt  = ST_IDLE;
          end else begin
            w_shift_en = 1'b1;
          end
        end else if (r_to_cnt == c_TO_MAX) begin
          w_timeout   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Stop bit is the current sample; parity covers D0..D7 plus parity bit
  assign w_frame_ok  = w_frame_done & (^r_shift) & r_dat_s;
  assign w_frame_bad = (w_frame_done & ~((^r_shift) & r_dat_s)) | w_timeout;

  // Bit counter, shift register and saturating stall timer
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bit_cnt <= 4'd0;
      r_shift   <= 9'd0;
      r_to_cnt  <= '0;
    end else begin
      if (r_state == ST_IDLE) r_bit_cnt <= 4'd0;
      else if (w_shift_en)    r_bit_cnt <= r_bit_cnt + 4'd1;

      if (w_shift_en) r_shift <= {r_dat_s, r_shift[8:1]};

      if (r_state != ST_RX || w_fall) r_to_cnt <= '0;
      else if (r_to_cnt != c_TO_MAX)  r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

  // Result stage: break prefix tracking, held scan code and one-cycle pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      r_brk         <= 1'b0;
      r_data_kb     <= 8'h00;
      r_key_release <= 1'b0;
      r_data_valid  <= 1'b0;
      r_rx_err      <= 1'b0;
    end else begin
      r_data_valid <= 1'b0;
      r_rx_err     <= 1'b0;
      if (w_frame_bad) begin
        r_rx_err <= 1'b1;
        r_brk    <= 1'b0;
      end else if (w_frame_ok) begin
        if (r_shift[7:0] == c_BREAK) begin
          r_brk <= 1'b1;
        end else if (r_shift[7:0] != c_EXTEND) begin
          r_data_kb     <= r_shift[7:0];
          r_key_release <= r_brk;
          r_data_valid  <= 1'b1;
          r_brk         <= 1'b0;
        end
      end
    end
  end

  assign kb.data_kb     = r_data_kb;
  assign kb.key_release = r_key_release;
  assign kb.data_valid  = r_data_valid;
  assign kb.rx_err      = r_rx_err;

endmodule
`default_nettype wire
